// File: rtl/cga_generation_controller.sv
// cga_generation_controller
// Compact-GA generation sequencer. Each generation samples candidate A and
// candidate B from the probability-vector population, offers each one to an
// external fitness evaluator, and then writes the fitter of the two back to
// the population as the winner. The block also tracks the best candidate seen
// in the run, counts completed generations, and stops on a generation limit or
// when a target fitness is reached.
//
// Optional feature macro: CGA_ELITISM_EN
//   When defined, every generation after the first uses the stored elite
//   (best_individual / best_fitness) as candidate B. The sample and evaluate
//   steps for B are then skipped and the generation goes straight from WT_A
//   to UPD. When undefined, both candidates are sampled and evaluated in every
//   generation.
module cga_generation_controller #(
    parameter int Width        = 32,
    parameter int FitnessWidth = 16,
    parameter int TaxWidth     = 4,
    parameter int GenWidth     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [TaxWidth-1:0]     cfg_tax,
    input  logic [GenWidth-1:0]     cfg_max_gen,
    input  logic [FitnessWidth-1:0] cfg_target,
    output logic                    pop_ce,
    output logic                    pop_we,
    output logic [TaxWidth-1:0]     pop_tax,
    output logic [Width-1:0]        pop_winner,
    input  logic [Width-1:0]        pop_individual,
    output logic                    eval_valid,
    input  logic                    eval_ready,
    output logic [Width-1:0]        eval_individual,
    input  logic                    fit_valid,
    input  logic [FitnessWidth-1:0] fit_value,
    output logic                    busy,
    output logic                    done,
    output logic [GenWidth-1:0]     generation,
    output logic [Width-1:0]        best_individual,
    output logic [FitnessWidth-1:0] best_fitness
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SMP_A,
        S_LAT_A,
        S_EVL_A,
        S_WT_A,
        S_SMP_B,
        S_LAT_B,
        S_EVL_B,
        S_WT_B,
        S_UPD,
        S_CHK,
        S_DONE
    } state_t;

    state_t                  state;
    logic [Width-1:0]        ind_a;
    logic [Width-1:0]        ind_b;
    logic [FitnessWidth-1:0] fit_a;
    logic                    best_valid;
    logic [GenWidth-1:0]     max_gen_q;
    logic [FitnessWidth-1:0] target_q;
    logic                    pop_we_q;

    logic                    fit_improves;
    logic [GenWidth-1:0]     gen_next;
    logic                    stop_run;
    logic [Width-1:0]        winner_ab;
    logic [Width-1:0]        winner_elite;
    logic                    elite_active;

    // The elite replaces candidate B only once a first generation has
    // completed. Before that no elite exists yet.
`ifdef CGA_ELITISM_EN
    assign elite_active = (generation != '0);
`else
    assign elite_active = 1'b0;
`endif

    // The update strobe is registered, but an abort arriving during UPD must
    // still stop the write. So the strobe is gated by abort in the same cycle.
    assign pop_we = pop_we_q & ~abort;

    // Helpers for best tracking, the saturating generation count, the stop test and the winner choice
    always_comb begin
        fit_improves = !best_valid || (fit_value > best_fitness);
        gen_next     = (generation == {GenWidth{1'b1}}) ? generation
                                                        : generation + GenWidth'(1);
        stop_run     = ((max_gen_q != '0) && (gen_next == max_gen_q)) ||
                       (best_fitness >= target_q);
        winner_ab    = (fit_value > fit_a) ? ind_b : ind_a;
        winner_elite = (best_fitness > fit_value) ? best_individual : ind_a;
    end

    // Generation sequencer: state, handshakes and registered outputs all move together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pop_ce          <= 1'b0;
            pop_we_q        <= 1'b0;
            pop_tax         <= '0;
            pop_winner      <= '0;
            eval_valid      <= 1'b0;
            eval_individual <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            generation      <= '0;
            best_individual <= '0;
            best_fitness    <= '0;
            best_valid      <= 1'b0;
            ind_a           <= '0;
            ind_b           <= '0;
            fit_a           <= '0;
            max_gen_q       <= '0;
            target_q        <= '0;
        end else begin
            pop_ce     <= 1'b0;
            pop_we_q   <= 1'b0;
            done       <= 1'b0;
            pop_winner <= '0;

            if (abort) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                eval_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state           <= S_SMP_A;
                            pop_ce          <= 1'b1;
                            busy            <= 1'b1;
                            pop_tax         <= cfg_tax;
                            max_gen_q       <= cfg_max_gen;
                            target_q        <= cfg_target;
                            generation      <= '0;
                            best_individual <= '0;
                            best_fitness    <= '0;
                            best_valid      <= 1'b0;
                        end
                    end

                    S_SMP_A: begin
                        state <= S_LAT_A;
                    end

                    S_LAT_A: begin
                        ind_a           <= pop_individual;
                        eval_individual <= pop_individual;
                        eval_valid      <= 1'b1;
                        state           <= S_EVL_A;
                    end

                    S_EVL_A: begin
                        if (eval_ready) begin
                            eval_valid <= 1'b0;
                            state      <= S_WT_A;
                        end
                    end

                    S_WT_A: begin
                        if (fit_valid) begin
                            fit_a <= fit_value;
                            if (fit_improves) begin
                                best_individual <= ind_a;
                                best_fitness    <= fit_value;
                                best_valid      <= 1'b1;
                            end
                            if (elite_active) begin
                                state      <= S_UPD;
                                pop_we_q   <= 1'b1;
                                pop_winner <= winner_elite;
                            end else begin
                                state  <= S_SMP_B;
                                pop_ce <= 1'b1;
                            end
                        end
                    end

                    S_SMP_B: begin
                        state <= S_LAT_B;
                    end

                    S_LAT_B: begin
                        ind_b           <= pop_individual;
                        eval_individual <= pop_individual;
                        eval_valid      <= 1'b1;
                        state           <= S_EVL_B;
                    end

                    S_EVL_B: begin
                        if (eval_ready) begin
                            eval_valid <= 1'b0;
                            state      <= S_WT_B;
                        end
                    end

                    S_WT_B: begin
                        if (fit_valid) begin
                            if (fit_improves) begin
                                best_individual <= ind_b;
                                best_fitness    <= fit_value;
                                best_valid      <= 1'b1;
                            end
                            state      <= S_UPD;
                            pop_we_q   <= 1'b1;
                            pop_winner <= winner_ab;
                        end
                    end

                    S_UPD: begin
                        state <= S_CHK;
                    end

                    S_CHK: begin
                        generation <= gen_next;
                        if (stop_run) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_SMP_A;
                            pop_ce <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        eval_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cga_generation_controller.sv
// tb_cga_generation_controller
// Randomized bench for the compact-GA generation controller. A small
// population stand-in and evaluator stand-in surround the DUT. A run-level
// reference model replays the recorded samples and fitness results using the
// compact-GA rules, and checks the winners, best-so-far, generation count and
// stop point. The bench follows CGA_ELITISM_EN in the same way as the design.
`timescale 1ns/100ps
module tb_cga_generation_controller;

`ifdef CGA_ELITISM_EN
    localparam bit Elite = 1'b1;
`else
    localparam bit Elite = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  cfg_tax;
    logic [15:0] cfg_max_gen;
    logic [15:0] cfg_target;
    logic        pop_ce;
    logic        pop_we;
    logic [3:0]  pop_tax;
    logic [7:0]  pop_winner;
    logic [7:0]  pop_individual;
    logic        eval_valid;
    logic        eval_ready;
    logic [7:0]  eval_individual;
    logic        fit_valid;
    logic [15:0] fit_value;
    logic        busy;
    logic        done;
    logic [15:0] generation;
    logic [7:0]  best_individual;
    logic [15:0] best_fitness;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  samples_q[$];
    logic [7:0]  evals_q[$];
    logic [7:0]  winners_q[$];
    logic [7:0]  forced_q[$];
    logic [15:0] fit_q[$];

    int cyc, first_ce_cyc, done_cyc, ce_cnt, we_cnt, done_cnt;
    bit popc_mode, stray_en;
    int rd_min, rd_max, fd_max;
    bit in_evl, pend;
    int wcnt, fdly;
    logic [15:0] pend_val;
    logic [7:0]  held;

    cga_generation_controller #(
        .Width        (8),
        .FitnessWidth (16),
        .TaxWidth     (4),
        .GenWidth     (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_tax         (cfg_tax),
        .cfg_max_gen     (cfg_max_gen),
        .cfg_target      (cfg_target),
        .pop_ce          (pop_ce),
        .pop_we          (pop_we),
        .pop_tax         (pop_tax),
        .pop_winner      (pop_winner),
        .pop_individual  (pop_individual),
        .eval_valid      (eval_valid),
        .eval_ready      (eval_ready),
        .eval_individual (eval_individual),
        .fit_valid       (fit_valid),
        .fit_value       (fit_value),
        .busy            (busy),
        .done            (done),
        .generation      (generation),
        .best_individual (best_individual),
        .best_fitness    (best_fitness)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] popcount8(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return 16'(c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Population and evaluator stand-ins. They sample the DUT at the falling
    // edge and drive responses for the rest of that cycle.
    initial begin
        logic [7:0]  v;
        logic [15:0] f;
        cyc = 0; ce_cnt = 0; we_cnt = 0; done_cnt = 0;
        first_ce_cyc = 0; done_cyc = 0;
        in_evl = 0; pend = 0; wcnt = 0; fdly = 0; pend_val = 0; held = 0;
        eval_ready = 0; fit_valid = 0; fit_value = 0; pop_individual = 0;
        forever begin
            @(negedge clk);
            cyc++;
            eval_ready = 1'b0;
            fit_valid  = 1'b0;
            if (!rst_n) begin
                in_evl = 0;
                pend   = 0;
            end else begin
                if (pop_ce) begin
                    if (ce_cnt == 0) first_ce_cyc = cyc;
                    ce_cnt++;
                    if (forced_q.size() > 0) v = forced_q.pop_front();
                    else v = 8'($urandom_range(0, 255));
                    pop_individual = v;
                    samples_q.push_back(v);
                end
                if (pop_we) begin
                    we_cnt++;
                    winners_q.push_back(pop_winner);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (eval_valid) begin
                    if (!in_evl) begin
                        in_evl = 1;
                        held   = eval_individual;
                        wcnt   = $urandom_range(rd_max, rd_min);
                    end else begin
                        checkOutput("eval_stable", eval_individual, held);
                    end
                    if (stray_en) begin
                        fit_valid = 1'b1;
                        fit_value = 16'hFFFF;
                    end
                    if (wcnt == 0) begin
                        eval_ready = 1'b1;
                        in_evl     = 0;
                        f = popc_mode ? popcount8(eval_individual) : 16'($urandom_range(0, 15));
                        evals_q.push_back(eval_individual);
                        fit_q.push_back(f);
                        pend     = 1;
                        pend_val = f;
                        fdly     = $urandom_range(fd_max, 0);
                    end else begin
                        wcnt--;
                    end
                end else if (pend) begin
                    if (fdly == 0) begin
                        fit_valid = 1'b1;
                        fit_value = pend_val;
                        pend      = 0;
                    end else begin
                        fdly--;
                        fit_value = 16'($urandom_range(0, 65535));
                    end
                end
            end
        end
    end

    task automatic setupRun(input bit popc, input int rmin, input int rmax, input int fmax, input bit stray);
        samples_q.delete(); evals_q.delete(); winners_q.delete(); fit_q.delete();
        ce_cnt = 0; we_cnt = 0; done_cnt = 0; first_ce_cyc = 0; done_cyc = 0;
        in_evl = 0; pend = 0;
        popc_mode = popc; rd_min = rmin; rd_max = rmax; fd_max = fmax; stray_en = stray;
    endtask

    // Replays the recorded run through the compact-GA rules and compares
    task automatic checkModel(input logic [15:0] maxg, input logic [15:0] target, input bit immediate);
        logic [15:0] g, fa, fb, bf;
        logic [7:0]  a, b, bi;
        bit bv, stop;
        int k, e, w;
        g = 0; bf = 0; bi = 0; bv = 0; stop = 0; k = 0; e = 0; w = 0;
        while (!stop && k < samples_q.size() && e < fit_q.size()) begin
            a  = samples_q[k]; k++;
            fa = fit_q[e];
            checkOutput("cand_a", evals_q[e], a); e++;
            if (!bv || fa > bf) begin bv = 1; bf = fa; bi = a; end
            if (Elite && g != 0) begin
                b = bi; fb = bf;
            end else begin
                if (k >= samples_q.size() || e >= fit_q.size()) break;
                b  = samples_q[k]; k++;
                fb = fit_q[e];
                checkOutput("cand_b", evals_q[e], b); e++;
                if (fb > bf) begin bf = fb; bi = b; end
            end
            if (w < winners_q.size()) checkOutput("winner", winners_q[w], (fb > fa) ? b : a);
            w++;
            g = (g == 16'hFFFF) ? g : g + 16'd1;
            stop = ((maxg != 0) && (g == maxg)) || (bf >= target);
        end
        checkOutput("done_pulses", done_cnt, stop ? 1 : 0);
        checkOutput("sample_count", samples_q.size(), k);
        checkOutput("eval_count", evals_q.size(), e);
        checkOutput("winner_count", winners_q.size(), w);
        checkOutput("generation", generation, g);
        checkOutput("best_individual", best_individual, bi);
        checkOutput("best_fitness", best_fitness, bf);
        if (immediate && g != 0)
            checkOutput("done_latency", done_cyc - first_ce_cyc,
                        Elite ? 10 + 6 * (int'(g) - 1) : 10 * int'(g));
    endtask

    // One complete run: latch config, start, poke an ignored start mid-run, then wait for done
    task automatic applyStimulus(input logic [3:0] tax, input logic [15:0] max_gen,
                                 input logic [15:0] target, input bit popc, input int rmin,
                                 input int rmax, input int fmax, input bit stray);
        int n;
        setupRun(popc, rmin, rmax, fmax, stray);
        @(posedge clk); #1;
        cfg_tax = tax; cfg_max_gen = max_gen; cfg_target = target; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_tax = ~tax; cfg_max_gen = 16'd1; cfg_target = 16'd0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("done_seen", done_cnt != 0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("pop_tax", pop_tax, tax);
        checkModel(max_gen, target, (rmax == 0) && (fmax == 0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_tax = 0; cfg_max_gen = 0; cfg_target = 0;
        setupRun(1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pop_ce", pop_ce, 1'b0);
        checkOutput("rst_pop_we", pop_we, 1'b0);
        checkOutput("rst_eval_valid", eval_valid, 1'b0);
        checkOutput("rst_generation", generation, 16'd0);
        checkOutput("rst_best_fit", best_fitness, 16'd0);
        checkOutput("rst_best_ind", best_individual, 8'd0);
        checkOutput("rst_pop_winner", pop_winner, 8'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of EVL_A
        $display("[TB] reset during evaluation");
        setupRun(1'b0, 3, 3, 0, 1'b0);
        @(posedge clk); #1;
        cfg_tax = 4'd5; cfg_max_gen = 0; cfg_target = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!eval_valid && n < 50) begin @(negedge clk); n++; end
        checkOutput("t1_eval_valid", eval_valid, 1'b1);
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_pop_tax", pop_tax, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_rst_eval_valid", eval_valid, 1'b0);
        checkOutput("t1_rst_busy", busy, 1'b0);
        checkOutput("t1_rst_pop_ce", pop_ce, 1'b0);
        checkOutput("t1_rst_pop_we", pop_we, 1'b0);
        checkOutput("t1_rst_pop_tax", pop_tax, 4'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Popcount fitness, three generation limit, immediate evaluator
        $display("[TB] generation limit run");
        applyStimulus(4'd2, 16'd3, 16'hFFFF, 1'b1, 0, 0, 0, 1'b0);
        checkOutput("t2_generation", generation, 16'd3);
        checkOutput("t2_pop_we", we_cnt, 3);
        checkOutput("t2_done_cycle", done_cyc - first_ce_cyc, Elite ? 22 : 30);

        // Equal fitness goes to candidate A
        $display("[TB] tie break");
        forced_q = '{8'h0F, 8'hF0};
        applyStimulus(4'd3, 16'd1, 16'hFFFF, 1'b1, 0, 0, 0, 1'b0);
        checkOutput("t3_tie_winner", winners_q[0], 8'h0F);

        // Target reached by candidate B in the first generation
        $display("[TB] target stop");
        forced_q = '{8'h01, 8'h3F};
        applyStimulus(4'd4, 16'd0, 16'd5, 1'b1, 0, 0, 0, 1'b0);
        checkOutput("t4_generation", generation, 16'd1);
        checkOutput("t4_best_fitness", best_fitness, 16'd6);
        checkOutput("t4_best_ind", best_individual, 8'h3F);

        // Slow ready with stray fit_valid pulses while waiting
        $display("[TB] slow evaluator with stray fitness strobes");
        applyStimulus(4'd1, 16'd2, 16'hFFFF, 1'b0, 5, 5, 0, 1'b1);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            applyStimulus(4'($urandom_range(0, 15)), 16'($urandom_range(1, 4)),
                          (r % 2 == 1) ? 16'($urandom_range(10, 15)) : 16'hFFFF,
                          1'b0, 0, $urandom_range(0, 2), $urandom_range(0, 2),
                          1'($urandom_range(0, 1)));
        end

        // Abort during the second generation's UPD cycle
        $display("[TB] abort during update");
        setupRun(1'b0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        cfg_tax = 4'd7; cfg_max_gen = 0; cfg_target = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (Elite ? 14 : 18) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t6_pop_we_count", we_cnt, 1);
        checkOutput("t6_pop_ce_count", ce_cnt, Elite ? 3 : 4);
        checkOutput("t6_no_done", done_cnt, 0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_generation", generation, 16'd1);
        checkOutput("t6_gen0_winner", winners_q[0],
                    (fit_q[1] > fit_q[0]) ? samples_q[1] : samples_q[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
